// File: rtl/kb_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : kb_event_fifo
// Description : Keyboard event queue behind the ZX-Uno scancode and status
//               registers. The CPU reads and flushes it through those ports.
// Revision    : 1.0 - initial release
// ============================================================================
module kb_event_fifo #(
    parameter int         DEPTH         = 8,
    parameter logic [7:0] SCANCODE_ADDR = 8'h04,
    parameter logic [7:0] KBSTATUS_ADDR = 8'h05
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     scan_received,
    input  logic [7:0]               scancode,
    input  logic                     extended,
    input  logic                     released,
    input  logic [7:0]               zxuno_addr,
    input  logic                     zxuno_regrd,
    input  logic                     zxuno_regwr,
    input  logic [7:0]               din,
    output logic [7:0]               scancode_dout,
    output logic                     oe_scancode,
    output logic [7:0]               kbstatus_dout,
    output logic                     oe_kbstatus,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = c_AW + 1;
    localparam logic [c_LW-1:0] c_FULL = c_LW'(DEPTH);

    logic [9:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_LW-1:0] r_level;
    logic            r_ovf;
    logic            r_oe_sc_d;
    logic            r_oe_ks_d;
    logic            r_regwr_d;

    logic            w_empty;
    logic            w_full;
    logic            w_flush;
    logic            w_pop;
    logic            w_push;
    logic            w_overflow;
    logic            w_ks_fall;
    logic [9:0]      w_head;
    logic            w_unused_din;

    assign oe_scancode  = (zxuno_addr == SCANCODE_ADDR) && zxuno_regrd;
    assign oe_kbstatus  = (zxuno_addr == KBSTATUS_ADDR) && zxuno_regrd;

    assign w_empty      = (r_level == '0);
    assign w_full       = (r_level == c_FULL);
    assign w_flush      = zxuno_regwr && !r_regwr_d &&
                          (zxuno_addr == KBSTATUS_ADDR) && din[0];
    // Pop fires once, on the falling edge of the scancode read strobe.
    assign w_pop        = r_oe_sc_d && !oe_scancode && !w_empty && !w_flush;
    assign w_push       = scan_received && (!w_full || w_pop) && !w_flush;
    assign w_overflow   = scan_received && w_full && !w_pop && !w_flush;
    assign w_ks_fall    = r_oe_ks_d && !oe_kbstatus;
    assign w_unused_din = ^din[7:1];

    assign w_head        = r_mem[r_rptr];
    assign scancode_dout = w_empty ? 8'h00 : w_head[7:0];
    assign kbstatus_dout = {1'b0, 3'b000, r_ovf,
                            w_head[9] & !w_empty,
                            w_head[8] & !w_empty,
                            !w_empty};
    assign fifo_level    = r_level;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {released, extended, scancode};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_level   <= '0;
            r_ovf     <= 1'b0;
            r_oe_sc_d <= 1'b0;
            r_oe_ks_d <= 1'b0;
            r_regwr_d <= 1'b0;
        end else begin
            r_oe_sc_d <= oe_scancode;
            r_oe_ks_d <= oe_kbstatus;
            r_regwr_d <= zxuno_regwr;
            if (w_flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_level <= '0;
                r_ovf   <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                if (w_push && !w_pop) begin
                    r_level <= r_level + 1'b1;
                end else if (w_pop && !w_push) begin
                    r_level <= r_level - 1'b1;
                end
                // A fresh overflow wins over the status-read clear.
                if (w_overflow) begin
                    r_ovf <= 1'b1;
                end else if (w_ks_fall) begin
                    r_ovf <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kb_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_kb_event_fifo
// Description : Directed self-checking bench for kb_event_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kb_event_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       scan_received;
    logic [7:0] scancode;
    logic       extended;
    logic       released;
    logic [7:0] zxuno_addr;
    logic       zxuno_regrd;
    logic       zxuno_regwr;
    logic [7:0] din;
    logic [7:0] scancode_dout;
    logic       oe_scancode;
    logic [7:0] kbstatus_dout;
    logic       oe_kbstatus;
    logic [3:0] fifo_level;

    int errors = 0;
    int checks = 0;

    kb_event_fifo #(.DEPTH(8), .SCANCODE_ADDR(8'h04), .KBSTATUS_ADDR(8'h05)) dut (
        .clk(clk), .rst(rst), .scan_received(scan_received), .scancode(scancode),
        .extended(extended), .released(released), .zxuno_addr(zxuno_addr),
        .zxuno_regrd(zxuno_regrd), .zxuno_regwr(zxuno_regwr), .din(din),
        .scancode_dout(scancode_dout), .oe_scancode(oe_scancode),
        .kbstatus_dout(kbstatus_dout), .oe_kbstatus(oe_kbstatus),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [7:0] code, input logic ext, input logic rls);
        @(negedge clk);
        scan_received = 1'b1;
        scancode      = code;
        extended      = ext;
        released      = rls;
        @(negedge clk);
        scan_received = 1'b0;
    endtask

    // Read strobe of n cycles; returns one negedge after the pop edge.
    task automatic rd(input logic [7:0] a, input int n);
        @(negedge clk);
        zxuno_addr  = a;
        zxuno_regrd = 1'b1;
        repeat (n) @(negedge clk);
        zxuno_regrd = 1'b0;
        @(negedge clk);
        zxuno_addr  = 8'h00;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        zxuno_addr  = a;
        din         = d;
        zxuno_regwr = 1'b1;
        repeat (2) @(negedge clk);
        zxuno_regwr = 1'b0;
        zxuno_addr  = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; scan_received = 0; scancode = 0; extended = 0; released = 0;
        zxuno_addr = 0; zxuno_regrd = 0; zxuno_regwr = 0; din = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++; if (scancode_dout !== 8'h00) begin errors++; $display("FAIL reset_sc got %h want 00", scancode_dout); end
        checks++; if (kbstatus_dout !== 8'h00) begin errors++; $display("FAIL reset_ks got %h want 00", kbstatus_dout); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_lvl got %0d want 0", fifo_level); end
        checks++; if (oe_scancode !== 1'b0 || oe_kbstatus !== 1'b0) begin errors++; $display("FAIL reset_oe got %b%b want 00", oe_scancode, oe_kbstatus); end
    endtask

    task automatic test_push_make;
        push(8'h1C, 1'b0, 1'b0);
        checks++; if (scancode_dout !== 8'h1C) begin errors++; $display("FAIL make_sc got %h want 1c", scancode_dout); end
        checks++; if (kbstatus_dout !== 8'h01) begin errors++; $display("FAIL make_ks got %h want 01", kbstatus_dout); end
        checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL make_lvl got %0d want 1", fifo_level); end
        rd(8'h04, 1);
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL make_pop got %0d want 0", fifo_level); end
    endtask

    task automatic test_ext_release;
        push(8'h75, 1'b1, 1'b1);
        checks++; if (scancode_dout !== 8'h75) begin errors++; $display("FAIL ext_sc got %h want 75", scancode_dout); end
        checks++; if (kbstatus_dout !== 8'h07) begin errors++; $display("FAIL ext_ks got %h want 07", kbstatus_dout); end
        @(negedge clk);
        zxuno_addr = 8'h04; zxuno_regrd = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (oe_scancode !== 1'b1) begin errors++; $display("FAIL ext_oe got %b want 1", oe_scancode); end
        checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL ext_early_pop got %0d want 1", fifo_level); end
        zxuno_regrd = 1'b0;
        @(negedge clk);
        zxuno_addr = 8'h00;
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL ext_pop got %0d want 0", fifo_level); end
        checks++; if (kbstatus_dout !== 8'h00) begin errors++; $display("FAIL ext_ks_empty got %h want 00", kbstatus_dout); end
        rd(8'h04, 2);
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL empty_pop got %0d want 0", fifo_level); end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 9; i++) push(8'h10 + 8'(i), 1'b0, 1'b0);
        checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL ovf_lvl got %0d want 8", fifo_level); end
        checks++; if (kbstatus_dout !== 8'h09) begin errors++; $display("FAIL ovf_ks got %h want 09", kbstatus_dout); end
        rd(8'h05, 2);
        checks++; if (kbstatus_dout[3] !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", kbstatus_dout[3]); end
        push(8'h99, 1'b0, 1'b0);
        // status read ends in the same cycle as another dropped event
        @(negedge clk);
        zxuno_addr = 8'h05; zxuno_regrd = 1'b1;
        @(negedge clk);
        zxuno_regrd = 1'b0; scan_received = 1'b1; scancode = 8'h9A;
        @(negedge clk);
        scan_received = 1'b0; zxuno_addr = 8'h00;
        checks++; if (kbstatus_dout[3] !== 1'b1) begin errors++; $display("FAIL ovf_keep got %b want 1", kbstatus_dout[3]); end
        rd(8'h05, 1);
        checks++; if (kbstatus_dout[3] !== 1'b0) begin errors++; $display("FAIL ovf_clear2 got %b want 0", kbstatus_dout[3]); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (scancode_dout !== 8'h10 + 8'(i)) begin errors++; $display("FAIL ovf_drain%0d got %h want %h", i, scancode_dout, 8'h10 + 8'(i)); end
            rd(8'h04, 1);
        end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL ovf_drained got %0d want 0", fifo_level); end
    endtask

    task automatic test_full_pushpop;
        for (int i = 0; i < 8; i++) push(8'h20 + 8'(i), 1'b0, 1'b0);
        @(negedge clk);
        zxuno_addr = 8'h04; zxuno_regrd = 1'b1;
        @(negedge clk);
        zxuno_regrd = 1'b0; scan_received = 1'b1; scancode = 8'h30;
        @(negedge clk);
        scan_received = 1'b0; zxuno_addr = 8'h00;
        checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL fpp_lvl got %0d want 8", fifo_level); end
        checks++; if (kbstatus_dout[3] !== 1'b0) begin errors++; $display("FAIL fpp_ovf got %b want 0", kbstatus_dout[3]); end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp;
            exp = (i < 7) ? 8'h21 + 8'(i) : 8'h30;
            checks++; if (scancode_dout !== exp) begin errors++; $display("FAIL fpp_drain%0d got %h want %h", i, scancode_dout, exp); end
            rd(8'h04, 1);
        end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL fpp_end got %0d want 0", fifo_level); end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 5; i++) push(8'h40 + 8'(i), 1'b1, 1'b0);
        @(negedge clk);
        zxuno_addr = 8'h05; din = 8'h01; zxuno_regwr = 1'b1;
        scan_received = 1'b1; scancode = 8'h4F;
        @(negedge clk);
        scan_received = 1'b0;
        @(negedge clk);
        zxuno_regwr = 1'b0; zxuno_addr = 8'h00;
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL flush_lvl got %0d want 0", fifo_level); end
        checks++; if (kbstatus_dout !== 8'h00) begin errors++; $display("FAIL flush_ks got %h want 00", kbstatus_dout); end
        checks++; if (scancode_dout !== 8'h00) begin errors++; $display("FAIL flush_sc got %h want 00", scancode_dout); end
        push(8'h51, 1'b0, 1'b0);
        push(8'h52, 1'b0, 1'b0);
        wr(8'h05, 8'h00);
        checks++; if (fifo_level !== 4'd2) begin errors++; $display("FAIL wr_din0 got %0d want 2", fifo_level); end
        wr(8'h04, 8'h01);
        checks++; if (fifo_level !== 4'd2 || scancode_dout !== 8'h51) begin errors++; $display("FAIL wr_sc got %0d/%h want 2/51", fifo_level, scancode_dout); end
        for (int i = 0; i < 7; i++) push(8'h60, 1'b0, 1'b0);
        wr(8'h05, 8'h01);
        checks++; if (kbstatus_dout !== 8'h00 || fifo_level !== 4'd0) begin errors++; $display("FAIL flush_ovf got %h/%0d want 00/0", kbstatus_dout, fifo_level); end
    endtask

    task automatic test_reset_during_read;
        for (int i = 0; i < 3; i++) push(8'h70 + 8'(i), 1'b0, 1'b1);
        @(negedge clk);
        zxuno_addr = 8'h04; zxuno_regrd = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (scancode_dout !== 8'h00 || kbstatus_dout !== 8'h00 || fifo_level !== 4'd0) begin errors++; $display("FAIL rstrd got %h/%h/%0d want 00/00/0", scancode_dout, kbstatus_dout, fifo_level); end
        @(negedge clk);
        zxuno_regrd = 1'b0;
        repeat (2) @(negedge clk);
        zxuno_addr = 8'h00;
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL rstrd_nopop got %0d want 0", fifo_level); end
        push(8'h5A, 1'b0, 1'b0);
        checks++; if (scancode_dout !== 8'h5A || fifo_level !== 4'd1) begin errors++; $display("FAIL rstrd_push got %h/%0d want 5a/1", scancode_dout, fifo_level); end
    endtask

    initial begin
        test_reset;
        test_push_make;
        test_ext_release;
        test_overflow;
        test_full_pushpop;
        test_flush;
        test_reset_during_read;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/kb_event_fifo.md
KB_EVENT_FIFO -- requirements
Module: kb_event_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the number of queued key events (power of two, 2..64).
REQ-002 SHALL have parameter SCANCODE_ADDR, default 8'h04, meaning the ZX-Uno register address of the scancode port.
REQ-003 SHALL have parameter KBSTATUS_ADDR, default 8'h05, meaning the ZX-Uno register address of the keyboard status port.
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-006 SHALL have port scan_received, input, 1, a one-cycle strobe marking a new key event.
REQ-007 SHALL have port scancode, input, 8, the key code, valid with scan_received.
REQ-008 SHALL have port extended, input, 1, the extended-code flag, valid with scan_received.
REQ-009 SHALL have port released, input, 1, the key-release flag, valid with scan_received.
REQ-010 SHALL have port zxuno_addr, input, 8, the currently selected ZX-Uno register.
REQ-011 SHALL have port zxuno_regrd, input, 1, the register read strobe (may span several cycles).
REQ-012 SHALL have port zxuno_regwr, input, 1, the register write strobe (may span several cycles).
REQ-013 SHALL have port din, input, 8, the CPU write data.
REQ-014 SHALL have port scancode_dout, output, 8, the head event code.
REQ-015 SHALL have port oe_scancode, output, 1, the scancode read-enable.
REQ-016 SHALL have port kbstatus_dout, output, 8, the status byte.
REQ-017 SHALL have port oe_kbstatus, output, 1, the status read-enable.
REQ-018 SHALL have port fifo_level, output, clog2(DEPTH)+1, the number of entries held.

Function
REQ-019 Entry SHALL be 10 bits {released, extended, scancode}, stored in a circular buffer with read/write pointers wrapping modulo DEPTH.
REQ-020 oe_scancode SHALL be combinational: (zxuno_addr==SCANCODE_ADDR && zxuno_regrd); oe_kbstatus SHALL be the same with KBSTATUS_ADDR.
REQ-021 Push: on scan_received with level<DEPTH, the entry SHALL be written at the write pointer and level incremented at that edge; the entry SHALL appear at the outputs the following cycle if the FIFO was empty.
REQ-022 Full: on scan_received with level==DEPTH and no pop in the same cycle, the event SHALL be dropped and the sticky OVF flag set.
REQ-023 scancode_dout SHALL show the head scancode when level>0, else 8'h00.
REQ-024 kbstatus_dout SHALL be {BSY=0, 3'b000, ERR=OVF, RLS=head released, EXT=head extended, PEN=(level>0)}; RLS/EXT SHALL read 0 when empty.
REQ-025 Pop: a registered flag SHALL track oe_scancode; on the first cycle oe_scancode is low after being high, the head SHALL be popped once if level>0, so one read access pops exactly one entry regardless of strobe length.
REQ-026 Pop on empty SHALL be ignored; level SHALL never underflow.
REQ-027 Simultaneous push and pop SHALL both occur and leave level unchanged, including when full (push accepted, OVF not set).
REQ-028 OVF SHALL clear on the first cycle oe_kbstatus is low after being high, unless an overflow occurs in that same cycle, in which case OVF SHALL remain set.
REQ-029 Flush: a write to KBSTATUS_ADDR with din[0]=1 SHALL, on the first cycle of zxuno_regwr, empty the FIFO (pointers and level to 0) and clear OVF; a push or pop in that cycle SHALL be discarded without setting OVF.
REQ-030 Writes to SCANCODE_ADDR, and KBSTATUS writes with din[0]=0, SHALL have no effect.

Reset
REQ-031 rst high at a clock edge SHALL set pointers, level, OVF and the strobe-tracking flags to 0, giving scancode_dout=8'h00 and kbstatus_dout=8'h00; this SHALL take priority over push, pop and flush.
REQ-032 Buffer storage contents need not be reset.

Verification
REQ-033 Reset, then push 8'h1C (make) -> next cycle scancode_dout=8'h1C, kbstatus_dout=8'h01, fifo_level=1.
REQ-034 Push E0/75 extended release, then read SCANCODE with a 3-cycle strobe -> head gives scancode_dout=8'h75, kbstatus_dout=8'h07; exactly one pop after strobe falls; fifo_level=0, kbstatus_dout=8'h00.
REQ-035 With DEPTH=8, push 9 events -> fifo_level=8, kbstatus_dout[3]=1, and the 9th event is lost; read KBSTATUS -> bit3 clears after the strobe.
REQ-036 With the FIFO full, a pop and a push in the same cycle -> fifo_level stays 8, OVF stays 0, and the new entry is the tail after 8 pops (checks pointer wrap).
REQ-037 With 5 entries queued, write 8'h01 to KBSTATUS together with scan_received -> fifo_level=0, OVF=0, scancode_dout=8'h00.
REQ-038 Assert rst during a SCANCODE read strobe with 3 entries queued -> all outputs read 0 next cycle, and no pop occurs when the strobe ends.
